// File: rtl/nn_pkg.sv
// Shared constants and types for the dense network front end and layers.
package nn_pkg;

  localparam int DATA_W = 32;
  localparam int N_FEAT = 8;
  localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  typedef logic [DATA_W-1:0] feat_word_t;

  // Loader framing state: FILL assembles words, DROP discards the rest of a long frame.
  typedef enum logic {
    FILL = 1'b0,
    DROP = 1'b1
  } ld_state_e;

endpackage

// File: rtl/feature_bank.sv
// One N_FEAT x DATA_W register bank: indexed single-word write, parallel read-out.
module feature_bank
  import nn_pkg::*;
#(
  parameter  int DATA_W = nn_pkg::DATA_W,
  parameter  int N_FEAT = nn_pkg::N_FEAT,
  localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o [N_FEAT-1:0]
);

  genvar g;
  for (g = 0; g < N_FEAT; g++) begin : g_word
    logic [DATA_W-1:0] word_q;

    // Capture the incoming word when this slot is addressed; reset clears contents.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 word_q <= '0;
      else if (we_i && idx_i == IDX_W'(g))     word_q <= data_i;
    end

    assign data_o[g] = word_q;
  end

endmodule

// File: rtl/feature_vector_loader.sv
// Streaming feature loader: assembles N_FEAT-word frames into a ping-pong
// buffer and hands complete vectors downstream; malformed frames are dropped.
module feature_vector_loader
  import nn_pkg::*;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int N_FEAT = nn_pkg::N_FEAT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] x_vec [N_FEAT-1:0],
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frames_done
);

  localparam int               IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);

  ld_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  frames_q, frames_d;

  logic              accept, handoff, fill_we;
  logic [DATA_W-1:0] a_vec [N_FEAT-1:0];
  logic [DATA_W-1:0] b_vec [N_FEAT-1:0];

  // Ready/valid come straight from registers; vec_ready never reaches s_ready.
  assign s_ready     = !rst && ((state_q == DROP) || !full_q[wr_bank_q]);
  assign vec_valid   = full_q[rd_bank_q];
  assign frame_err   = err_q;
  assign frames_done = frames_q;

  assign accept  = s_valid && s_ready;
  assign handoff = vec_valid && vec_ready;
  assign fill_we = accept && (state_q == FILL);

  feature_bank #(.DATA_W(DATA_W), .N_FEAT(N_FEAT)) u_bank_a (
    .clk    (clk),
    .rst    (rst),
    .we_i   (fill_we && !wr_bank_q),
    .idx_i  (idx_q),
    .data_i (s_data),
    .data_o (a_vec)
  );

  feature_bank #(.DATA_W(DATA_W), .N_FEAT(N_FEAT)) u_bank_b (
    .clk    (clk),
    .rst    (rst),
    .we_i   (fill_we && wr_bank_q),
    .idx_i  (idx_q),
    .data_i (s_data),
    .data_o (b_vec)
  );

  // Present the read bank as the parallel input vector.
  always_comb begin
    for (int i = 0; i < N_FEAT; i++) begin
      x_vec[i] = rd_bank_q ? b_vec[i] : a_vec[i];
    end
  end

  // Next state: read-side handoff and write-side framing are independent, so a
  // completion and a handoff in the same cycle both land (they never target
  // the same bank: completion needs wr bank empty, handoff needs rd bank full).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    err_d     = 1'b0;
    frames_d  = frames_q;

    if (handoff) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
      frames_d          = frames_q + 1'b1;
    end

    if (accept) begin
      case (state_q)
        FILL: begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (s_last) begin
              full_d[wr_bank_q] = 1'b1;
              wr_bank_d         = !wr_bank_q;
            end else begin
              err_d   = 1'b1;   // long frame: flag once, swallow the tail
              state_d = DROP;
            end
          end else if (s_last) begin
            err_d = 1'b1;       // short frame: partial bank simply gets overwritten
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DROP: begin
          if (s_last) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Framing FSM and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Buffer bookkeeping: bank flags, pointers and handoff counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      frames_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      frames_q  <= frames_d;
    end
  end

endmodule
